// File: rtl/iob_cache_fe_pkg.sv
// Entry layout for the pipelined IOb cache front-end: {is_ctrl, addr, wdata, wstrb}, MSB to LSB.
// Latency: n/a (types and constant helpers only); backpressure: n/a.
package iob_cache_fe_pkg;

  localparam int IOB_CACHE_SWREG_ADDR_W = 5;
  localparam int FE_WSTRB_LSB = 0;

  typedef enum logic {
    DST_DATA = 1'b0,
    DST_CTRL = 1'b1
  } fe_dst_e;

  function automatic int fe_addr_w(input int addr_w, input int use_ctrl);
    return addr_w - use_ctrl;
  endfunction

  function automatic int fe_entry_w(input int addr_w, input int data_w, input int use_ctrl);
    return 1 + fe_addr_w(addr_w, use_ctrl) + data_w + data_w / 8;
  endfunction

  function automatic int fe_wdata_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int fe_addr_lsb(input int data_w);
    return data_w / 8 + data_w;
  endfunction

  function automatic int fe_ctrl_bit(input int addr_w, input int data_w, input int use_ctrl);
    return fe_addr_lsb(data_w) + fe_addr_w(addr_w, use_ctrl);
  endfunction

endpackage

// File: rtl/iob_cache_fe_fifo.sv
// Generic synchronous FIFO with async active-high reset; head data is read straight from storage.
// Latency: push visible at head next cycle; backpressure: push ignored when full, pop ignored when empty.
module iob_cache_fe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + 1'b1;
    end
    if (rd_en) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/iob_cache_front_end_pipe.sv
// Pipelined IOb front-end: in-order request queue feeding cache data path or control block (IOB_CACHE_FE_PERF_EN adds a stall counter).
// Latency: accepted request issues next cycle, read data returned combinationally on ack; backpressure: iob_ready_o low while queue full.
module iob_cache_front_end_pipe
  import iob_cache_fe_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int USE_CTRL = 0,
  parameter int DEPTH    = 2,
  parameter int PTR_W    = $clog2(DEPTH)
) (
  input  logic                              clk_i,
  input  logic                              cke_i,
  input  logic                              arst_i,
  input  logic                              iob_avalid_i,
  input  logic [ADDR_W-1:0]                 iob_addr_i,
  input  logic [DATA_W-1:0]                 iob_wdata_i,
  input  logic [DATA_W/8-1:0]               iob_wstrb_i,
  output logic                              iob_ready_o,
  output logic                              iob_rvalid_o,
  output logic [DATA_W-1:0]                 iob_rdata_o,
  output logic                              data_req_o,
  output logic [ADDR_W-USE_CTRL-1:0]        data_addr_o,
  output logic [DATA_W-1:0]                 data_wdata_o,
  output logic [DATA_W/8-1:0]               data_wstrb_o,
  input  logic [DATA_W-1:0]                 data_rdata_i,
  input  logic                              data_ack_i,
  output logic                              ctrl_req_o,
  output logic [IOB_CACHE_SWREG_ADDR_W-1:0] ctrl_addr_o,
  input  logic [DATA_W-1:0]                 ctrl_rdata_i,
  input  logic                              ctrl_ack_i,
  output logic [PTR_W:0]                    level_o
`ifdef IOB_CACHE_FE_PERF_EN
  ,
  input  logic                              stall_clr_i,
  output logic [31:0]                       stall_cnt_o
`endif
);

  localparam int AW        = fe_addr_w(ADDR_W, USE_CTRL);
  localparam int SW        = DATA_W / 8;
  localparam int ENTRY_W   = fe_entry_w(ADDR_W, DATA_W, USE_CTRL);
  localparam int WDATA_LSB = fe_wdata_lsb(DATA_W);
  localparam int ADDR_LSB  = fe_addr_lsb(DATA_W);
  localparam int CTRL_BIT  = fe_ctrl_bit(ADDR_W, DATA_W, USE_CTRL);

  logic               in_is_ctrl;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  fe_dst_e            head_dst;
  logic [AW-1:0]      head_addr;
  logic [SW-1:0]      head_wstrb;

  generate
    if (USE_CTRL != 0) begin : g_ctrl_dec
      assign in_is_ctrl  = iob_addr_i[ADDR_W-1];
      assign ctrl_addr_o = head_addr[IOB_CACHE_SWREG_ADDR_W-1:0];
    end else begin : g_no_ctrl_dec
      assign in_is_ctrl  = 1'b0;
      assign ctrl_addr_o = '0;
    end
  endgenerate

  assign in_entry = {in_is_ctrl, iob_addr_i[AW-1:0], iob_wdata_i, iob_wstrb_i};

  iob_cache_fe_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (push),
    .data_i  (in_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign head_addr  = head_entry[ADDR_LSB +: AW];
  assign head_wstrb = head_entry[FE_WSTRB_LSB +: SW];
  // The stored control bit is masked so a data-only build can never route to control.
  assign head_dst   = fe_dst_e'(head_entry[CTRL_BIT] & (USE_CTRL != 0));

  always_comb begin
    iob_ready_o  = ~fifo_full;
    data_req_o   = ~fifo_empty & (head_dst == DST_DATA);
    ctrl_req_o   = ~fifo_empty & (head_dst == DST_CTRL);
    data_addr_o  = head_addr;
    data_wdata_o = head_entry[WDATA_LSB +: DATA_W];
    data_wstrb_o = head_wstrb;
    push         = cke_i & iob_avalid_i & iob_ready_o;
    pop          = cke_i & ((data_ack_i & data_req_o) | (ctrl_ack_i & ctrl_req_o));
    iob_rvalid_o = pop & (head_wstrb == '0);
    iob_rdata_o  = (head_dst == DST_CTRL) ? ctrl_rdata_i : data_rdata_i;
  end

`ifdef IOB_CACHE_FE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cke_i) begin
      if (stall_clr_i) begin
        stall_cnt_d = '0;
      end else if (iob_avalid_i & ~iob_ready_o & ~(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_iob_cache_front_end_pipe.sv
// Directed bench for iob_cache_front_end_pipe with USE_CTRL=1, DEPTH=2; inputs change on the falling edge.
// Define IOB_CACHE_FE_PERF_EN to include the stall-counter steps.
module tb_iob_cache_front_end_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke;
  logic        avalid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        data_req;
  logic [30:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        ctrl_req;
  logic [4:0]  ctrl_addr;
  logic [31:0] ctrl_rdata;
  logic        ctrl_ack;
  logic [1:0]  level;
`ifdef IOB_CACHE_FE_PERF_EN
  logic        stall_clr;
  logic [31:0] stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  iob_cache_front_end_pipe #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .USE_CTRL (1),
    .DEPTH    (2)
  ) dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .arst_i       (rst),
    .iob_avalid_i (avalid),
    .iob_addr_i   (addr),
    .iob_wdata_i  (wdata),
    .iob_wstrb_i  (wstrb),
    .iob_ready_o  (ready),
    .iob_rvalid_o (rvalid),
    .iob_rdata_o  (rdata),
    .data_req_o   (data_req),
    .data_addr_o  (data_addr),
    .data_wdata_o (data_wdata),
    .data_wstrb_o (data_wstrb),
    .data_rdata_i (data_rdata),
    .data_ack_i   (data_ack),
    .ctrl_req_o   (ctrl_req),
    .ctrl_addr_o  (ctrl_addr),
    .ctrl_rdata_i (ctrl_rdata),
    .ctrl_ack_i   (ctrl_ack),
    .level_o      (level)
`ifdef IOB_CACHE_FE_PERF_EN
    ,
    .stall_clr_i  (stall_clr),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    avalid = 1'b1;
    addr   = a;
    wdata  = d;
    wstrb  = s;
  endtask

  task automatic idle();
    avalid = 1'b0;
    addr   = '0;
    wdata  = '0;
    wstrb  = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cke = 1'b1; idle();
    data_rdata = '0; data_ack = 1'b0; ctrl_rdata = '0; ctrl_ack = 1'b0;
`ifdef IOB_CACHE_FE_PERF_EN
    stall_clr = 1'b0;
`endif
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_data_req", data_req, 0);
    chk("rst_ctrl_req", ctrl_req, 0);
    chk("rst_level", level, 0);
    chk("rst_data_addr", data_addr, 0);
`ifdef IOB_CACHE_FE_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_ready", ready, 1);
    chk("idle_data_req", data_req, 0);
    chk("idle_level", level, 0);

    // Two back-to-back reads with no ack
    req(32'h10, 32'h0, 4'h0); #1;
    chk("no_same_cycle_issue", data_req, 0);
    tick(); req(32'h14, 32'h0, 4'h0); #1;
    chk("rd1_issue_req", data_req, 1);
    chk("rd1_issue_addr", data_addr, 32'h10);
    chk("rd1_level", level, 1);
    tick(); idle(); #1;
    chk("full_level", level, 2);
    chk("full_ready", ready, 0);
    chk("full_head_addr", data_addr, 32'h10);
    tick(); #1;
    chk("held_req", data_req, 1);
    chk("held_addr", data_addr, 32'h10);
    data_ack = 1'b1; data_rdata = 32'hA5A5_A5A5; #1;
    chk("rd1_rvalid", rvalid, 1);
    chk("rd1_rdata", rdata, 32'hA5A5_A5A5);
    chk("no_full_bypass", ready, 0);
    tick(); data_ack = 1'b0; #1;
    chk("rd2_head_addr", data_addr, 32'h14);
    chk("ready_after_pop", ready, 1);
    chk("level_after_pop", level, 1);
    chk("rvalid_idle", rvalid, 0);
    data_ack = 1'b1; data_rdata = 32'h1234_5678; #1;
    chk("rd2_rvalid", rvalid, 1);
    chk("rd2_rdata", rdata, 32'h1234_5678);
    tick(); data_ack = 1'b0; #1;
    chk("drained_level", level, 0);
    chk("drained_req", data_req, 0);

    // Write: response suppressed
    req(32'h20, 32'hDEAD_BEEF, 4'hF);
    tick(); idle(); #1;
    chk("wr_req", data_req, 1);
    chk("wr_addr", data_addr, 32'h20);
    chk("wr_wdata", data_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", data_wstrb, 4'hF);
    data_ack = 1'b1; #1;
    chk("wr_no_rvalid", rvalid, 0);
    tick(); data_ack = 1'b0; #1;
    chk("wr_level", level, 0);

    // Stray acks on empty queue
    data_ack = 1'b1; ctrl_ack = 1'b1; #1;
    chk("empty_ack_rvalid", rvalid, 0);
    tick(); data_ack = 1'b0; ctrl_ack = 1'b0; #1;
    chk("empty_ack_level", level, 0);
    chk("empty_ack_ready", ready, 1);

    // Control then data: order preserved
    req(32'h8000_0004, 32'h0, 4'h0);
    tick(); req(32'h0000_0008, 32'h0, 4'h0); #1;
    chk("ctrl_req", ctrl_req, 1);
    chk("ctrl_addr", ctrl_addr, 4);
    chk("ctrl_first_no_data_req", data_req, 0);
    tick(); idle(); data_ack = 1'b1; #1;
    chk("wrong_ack_rvalid", rvalid, 0);
    tick(); data_ack = 1'b0; #1;
    chk("wrong_ack_level", level, 2);
    chk("ctrl_req_held", ctrl_req, 1);
    ctrl_ack = 1'b1; ctrl_rdata = 32'hC0DE_0001; data_rdata = 32'h0BAD_0BAD; #1;
    chk("ctrl_rvalid", rvalid, 1);
    chk("ctrl_rdata", rdata, 32'hC0DE_0001);
    tick(); ctrl_ack = 1'b0; #1;
    chk("after_ctrl_ctrl_req", ctrl_req, 0);
    chk("after_ctrl_data_req", data_req, 1);
    chk("after_ctrl_data_addr", data_addr, 32'h8);
    chk("after_ctrl_level", level, 1);

    // Clock enable low freezes the queue
    cke = 1'b0; data_ack = 1'b1; #1;
    chk("cke_low_rvalid", rvalid, 0);
    tick(); cke = 1'b1; data_ack = 1'b0; #1;
    chk("cke_low_level", level, 1);
    chk("cke_low_req", data_req, 1);
    data_ack = 1'b1; #1;
    chk("data_rvalid", rvalid, 1);
    chk("data_rdata", rdata, 32'h0BAD_0BAD);
    tick(); data_ack = 1'b0; #1;
    chk("order_level", level, 0);

    // Asynchronous reset with two entries queued
    req(32'h40, 32'h0, 4'h0);
    tick(); req(32'h44, 32'h0, 4'h0);
    tick(); idle(); #1;
    chk("pre_rst_level", level, 2);
    chk("pre_rst_req", data_req, 1);
    #2; rst = 1'b1; #1;
    chk("arst_req", data_req, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", ready, 1);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_level", level, 0);

`ifdef IOB_CACHE_FE_PERF_EN
    // Two pushes fill the queue, then five stalled cycles
    req(32'h50, 32'h0, 4'h0);
    repeat (7) tick();
    idle(); #1;
    chk("stall_level", level, 2);
    chk("stall_cnt", stall_cnt, 5);
    req(32'h58, 32'h0, 4'h0); stall_clr = 1'b1;
    tick(); idle(); stall_clr = 1'b0; #1;
    chk("stall_clr", stall_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
